// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver:
// FSM encoding, ratio floor and receive FIFO entry layout.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BRK_WAIT
   } rx_state_e;

   localparam int MIN_RATIO = 4;

   // flag offsets are relative to the top of the data field
   localparam int OFS_DATA    = 0;
   localparam int OFS_PAR_ERR = 0;
   localparam int OFS_FRM_ERR = 1;
   localparam int OFS_BREAK   = 2;
   localparam int FLAG_BITS   = 3;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO; head reads as zero when empty.
// Push while full succeeds only when a pop frees a slot the same cycle.
module uart_rx_fifo #(
   parameter int  WIDTH = 11,
   parameter int  DEPTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level
);

   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             wr;
   logic             rd;

   assign empty = (level == '0);
   assign full  = (level == FULL_LVL);
   assign rd    = pop & ~empty;
   assign wr    = push & (~full | rd);
   assign rdata = empty ? '0 : mem[rptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (wr) wptr <= wptr + AW'(1);
         if (rd) rptr <= rptr + AW'(1);
         unique case ({wr, rd})
            2'b10:   level <= level + (AW+1)'(1);
            2'b01:   level <= level - (AW+1)'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr) mem[wptr] <= wdata;
   end

endmodule

// File: rtl/uart_rx_ovs.sv
// UART receiver: 2-flop sync, 3-sample mid-bit majority vote, parity,
// framing and break detection, feeding a FWFT receive FIFO.
module uart_rx_ovs
   import uart_pkg::*;
#(
   parameter int  RATIO_REG_SIZE = 16,
   parameter int  DATA_BITS      = 8,
   parameter int  FIFO_DEPTH     = 8,
   localparam int LW             = $clog2(DATA_BITS+1),
   localparam int AW             = $clog2(FIFO_DEPTH)
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [RATIO_REG_SIZE-1:0] ratio,
   input  logic                      rx_enb,
   input  logic [LW-1:0]             data_len,
   input  logic                      parity_en,
   input  logic                      parity_odd,
   input  logic                      two_stop,
   input  logic                      UART_RX,
   output logic                      busy,
   output logic                      rx_valid,
   input  logic                      rx_ready,
   output logic [DATA_BITS-1:0]      rx_data,
   output logic                      rx_parity_err,
   output logic                      rx_frame_err,
   output logic                      rx_break,
   output logic                      overrun,
   input  logic                      clr_overrun,
   output logic [AW:0]               fifo_level
);

   localparam int RW = RATIO_REG_SIZE;
   localparam int EW = DATA_BITS + FLAG_BITS;

   rx_state_e            state;
   logic                 rx_m, rx_s;
   logic [RW-1:0]        r_lat, cnt, half;
   logic [LW-1:0]        len_lat, bit_idx;
   logic                 par_en, par_odd, two_lat, stop_idx;
   logic [DATA_BITS-1:0] shreg;
   logic [1:0]           v;
   logic                 par_err, frm_err, all_zero;
   logic                 s0, s1, dec, wrap, maj, brk, last_stop;
   logic                 push, pop, fifo_full, fifo_empty;
   logic [EW-1:0]        entry_d, push_entry, head;

   assign half      = r_lat >> 1;
   assign s0        = (cnt == half - RW'(1));
   assign s1        = (cnt == half);
   assign dec       = (cnt == half + RW'(1));
   assign wrap      = (cnt == r_lat - RW'(1));
   assign maj       = (v[0] & v[1]) | (rx_s & (v[0] | v[1]));
   assign last_stop = (stop_idx == two_lat);
   assign brk       = all_zero & ~maj;

   assign rx_valid      = ~fifo_empty;
   assign pop           = rx_valid & rx_ready;
   assign rx_data       = head[OFS_DATA +: DATA_BITS];
   assign rx_parity_err = head[DATA_BITS + OFS_PAR_ERR];
   assign rx_frame_err  = head[DATA_BITS + OFS_FRM_ERR];
   assign rx_break      = head[DATA_BITS + OFS_BREAK];

   // entry as it would be pushed at the final stop-bit decision
   always_comb begin
      entry_d = '0;
      entry_d[OFS_DATA +: DATA_BITS]     = brk ? '0 : shreg;
      entry_d[DATA_BITS + OFS_PAR_ERR] = par_err & ~brk;
      entry_d[DATA_BITS + OFS_FRM_ERR] = brk | frm_err | ~maj;
      entry_d[DATA_BITS + OFS_BREAK]   = brk;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) {rx_m, rx_s} <= 2'b11;
      else          {rx_m, rx_s} <= {UART_RX, rx_m};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         busy       <= 1'b0;
         cnt        <= '0;
         r_lat      <= RW'(MIN_RATIO);
         len_lat    <= LW'(DATA_BITS);
         par_en     <= 1'b0;
         par_odd    <= 1'b0;
         two_lat    <= 1'b0;
         bit_idx    <= '0;
         stop_idx   <= 1'b0;
         shreg      <= '0;
         v          <= '0;
         par_err    <= 1'b0;
         frm_err    <= 1'b0;
         all_zero   <= 1'b0;
         push       <= 1'b0;
         push_entry <= '0;
      end else begin
         push <= 1'b0;
         if (state != ST_IDLE && state != ST_BRK_WAIT) begin
            cnt <= wrap ? '0 : cnt + RW'(1);
            if (s0) v[0] <= rx_s;
            if (s1) v[1] <= rx_s;
         end
         unique case (state)
            ST_IDLE: begin
               if (!rx_s && rx_enb) begin
                  state    <= ST_START;
                  busy     <= 1'b1;
                  cnt      <= '0;
                  r_lat    <= (ratio < RW'(MIN_RATIO)) ?
                              RW'(MIN_RATIO) : ratio;
                  len_lat  <= (data_len < LW'(5) ||
                               data_len > LW'(DATA_BITS)) ?
                              LW'(DATA_BITS) : data_len;
                  par_en   <= parity_en;
                  par_odd  <= parity_odd;
                  two_lat  <= two_stop;
                  bit_idx  <= '0;
                  stop_idx <= 1'b0;
                  shreg    <= '0;
                  par_err  <= 1'b0;
                  frm_err  <= 1'b0;
                  all_zero <= 1'b1;
               end
            end
            ST_START: begin
               if (wrap) state <= ST_DATA;
               if (dec && maj) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end
            ST_DATA: begin
               if (dec) begin
                  shreg <= shreg | (DATA_BITS'(maj) << bit_idx);
                  if (maj) all_zero <= 1'b0;
               end
               if (wrap) begin
                  bit_idx <= bit_idx + LW'(1);
                  if (bit_idx == len_lat - LW'(1))
                     state <= par_en ? ST_PARITY : ST_STOP;
               end
            end
            ST_PARITY: begin
               if (dec) begin
                  par_err <= ((^shreg) ^ maj) != par_odd;
                  if (maj) all_zero <= 1'b0;
               end
               if (wrap) state <= ST_STOP;
            end
            ST_STOP: begin
               if (dec && !last_stop) begin
                  frm_err <= frm_err | ~maj;
                  if (maj) all_zero <= 1'b0;
               end
               if (wrap) stop_idx <= 1'b1;
               // leave mid-bit so a back-to-back start is not missed
               if (dec && last_stop) begin
                  push       <= 1'b1;
                  push_entry <= entry_d;
                  state      <= brk ? ST_BRK_WAIT : ST_IDLE;
                  busy       <= brk;
               end
            end
            ST_BRK_WAIT: begin
               if (rx_s) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                     overrun <= 1'b0;
      else if (push && fifo_full && !pop) overrun <= 1'b1;
      else if (clr_overrun)             overrun <= 1'b0;
   end

   uart_rx_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .wdata   (push_entry),
      .pop     (pop),
      .rdata   (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

endmodule

// File: doc/uart_rx_ovs.md
# uart_rx_ovs

Parametrised UART receiver, successor to the single-byte receiver. Adds a 2-flop input synchronizer, 3-sample majority voting at mid-bit, false-start rejection, runtime word length, 1/2 stop bits, framing and break detection, and a first-word-fall-through receive FIFO with overrun flag. Sits between the pad `UART_RX` and the bus-side register block, which pops received words.

## Interface
- `RATIO_REG_SIZE`, 16: width of `ratio` (clocks per bit).
- `DATA_BITS`, 8: maximum data bits per frame (≥5).
- `FIFO_DEPTH`, 8: receive FIFO entries, power of two ≥2.
- `clk`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ratio`  in  RATIO_REG_SIZE  clocks per bit; values <4 behave as 4.
- `rx_enb`  in  1  enables detection of new start bits.
- `data_len`  in  $clog2(DATA_BITS+1)  bits per frame, 5..DATA_BITS; out-of-range behaves as DATA_BITS.
- `parity_en`  in  1  parity bit present.
- `parity_odd`  in  1  1 = odd parity, 0 = even.
- `two_stop`  in  1  two stop bits expected.
- `UART_RX`  in  1  asynchronous serial line, idle high.
- `busy`  out  1  frame in progress.
- `rx_valid`  out  1  FIFO non-empty; head word on outputs.
- `rx_ready`  in  1  pop head when `rx_valid & rx_ready`.
- `rx_data`  out  DATA_BITS  head data, LSB first on line, unused MSBs zero.
- `rx_parity_err`, `rx_frame_err`, `rx_break`  out  1 each  head status.
- `overrun`  out  1  sticky: a frame was dropped on full FIFO.
- `clr_overrun`  in  1  clears `overrun`.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current occupancy.

## Operation
- All outputs reset to 0; FSM to IDLE; FIFO empty.
- Line passes 2-flop synchronizer (`rx_s`), reset value 1.
- States: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
- IDLE: `rx_s==0 & rx_enb` → START; latch `ratio`, `data_len`, `parity_en`, `parity_odd`, `two_stop`; bit counter `cnt`=0; `busy`=1.
- Per bit: `cnt` counts 0..R-1 (R = latched ratio), wraps and advances bit. Samples at `cnt` = R/2−1, R/2, R/2+1; bit value = majority; decision taken at R/2+1.
- START: majority 1 → false start, back to IDLE, nothing pushed.
- DATA: shift `data_len` bits LSB first. Then PARITY if enabled, else STOP.
- PARITY: `parity_err` = ones(data)+parity bit has wrong sense for `parity_odd`.
- STOP: each stop bit sampled; any 0 sets `frame_err`. After last stop-bit decision, push entry {break, frame_err, parity_err, data}; go to IDLE (or BRK_WAIT) immediately, not at end of stop bit.
- Break: all data, parity (if present) and stop bits 0 → `rx_break`=1, `rx_frame_err`=1, data 0; FSM enters BRK_WAIT until `rx_s==1`, then IDLE.
- `rx_enb` deassert mid-frame: frame completes normally; only new starts are gated. Config changes mid-frame ignored.
- Push when full, no pop same cycle: entry dropped, `overrun` set. Push and pop same cycle when full: both succeed, no overrun. Set and `clr_overrun` same cycle: set wins.

## Timing
- Synchronizer: 2 cycles from pad edge to `rx_s`.
- Push occurs the cycle after the last stop-bit decision; `rx_valid`/head outputs update the following cycle.
- Pop: head outputs advance the cycle after `rx_valid & rx_ready`; `fifo_level` updates same edge.
- `busy` falls the same edge the FSM re-enters IDLE.
- Reset mid-frame: frame discarded, FIFO emptied, `overrun` cleared.

## Structure
- Package `uart_pkg`: FSM state encoding, MIN_RATIO=4, FIFO entry field offsets (data, parity_err, frame_err, break).
- Sub-module `uart_rx_fifo`: synchronous FWFT FIFO, width DATA_BITS+3, depth FIFO_DEPTH, full/empty/level, async active-low reset. FSM, sampler and synchronizer stay in `uart_rx_ovs`.

## Test plan
- R=16, 8N1, send 0xA5, `rx_ready`=0 → after frame `rx_valid`=1, `rx_data`=0xA5, all error flags 0, `fifo_level`=1.
- 7E2 (`data_len`=7, parity even, `two_stop`=1), send 0x35 with wrong parity bit → `rx_data`=0x35, `rx_parity_err`=1, `rx_frame_err`=0.
- 0-glitch of 3 cycles on idle line, R=16 → no push, `busy` returns 0 within R/2+4 cycles.
- Single-cycle 1-glitch at mid of data bit 0 of 0x00 → majority rejects it, `rx_data`=0x00.
- Line held low 20 bit times, 8N1 → one entry, `rx_break`=1, `rx_frame_err`=1, data 0; no further entries until line high and new start.
- FIFO_DEPTH=4, send 5 frames with `rx_ready`=0 → `fifo_level`=4, `overrun`=1, pops return frames 1–4; `clr_overrun` clears flag.
